factorial_seq: RTL and testbench

//  Iterative factorial sequencer.
//  - Consumes the 4-bit operand N held in the upstream 4-bit operand register (n_in).
//  - On start, computes N! with a shift-add multiplier, one multiplier bit per cycle.
//  - Presents the result with a one-cycle done pulse to the downstream result/output stage.

---
 rtl/factorial_seq_if.sv | 23 ++
 rtl/factorial_seq.sv | 100 ++++++++++
 tb/tb_factorial_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/factorial_seq_if.sv
// Handshake/result bundle between the factorial sequencer and its neighbours.
// The upstream stage drives start/n_in; the sequencer drives the status and the result.
interface factorial_seq_if #(
    parameter int N_W   = 4,
    parameter int RES_W = 64
);
    logic             start;
    logic [N_W-1:0]   n_in;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result;
    logic             overflow;

    modport master (
        output start, n_in,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, n_in,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/factorial_seq.sv
// Iterative N! sequencer. Each factor is applied with a shift-add multiplier
// that consumes one multiplier bit per clock; the result is presented with a one-cycle done pulse.
module factorial_seq #(
    parameter int N_W   = 4,
    parameter int RES_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    factorial_seq_if.slave  bus
);
    localparam int P_W = RES_W + N_W;
    localparam int B_W = (N_W > 1) ? $clog2(N_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [N_W-1:0]   cnt_q;
    logic [B_W-1:0]   bit_q;
    logic [RES_W-1:0] acc_q;
    logic [P_W-1:0]   p_q;
    logic [RES_W-1:0] result_q;
    logic             overflow_q;

    logic [P_W-1:0]   p_d;
    logic             last_bit_s;

    // Partial product including the current multiplier bit.
    always_comb begin
        p_d        = p_q;
        last_bit_s = (bit_q == B_W'(N_W - 1));
        if (cnt_q[bit_q]) begin
            p_d = p_q + ({{N_W{1'b0}}, acc_q} << bit_q);
        end else begin
            p_d = p_q;
        end
    end

    // Sequencer state, datapath registers and the held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            acc_q      <= '0;
            p_q        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        cnt_q      <= bus.n_in;
                        acc_q      <= RES_W'(1);
                        overflow_q <= 1'b0;
                        p_q        <= '0;
                        bit_q      <= '0;
                        if (bus.n_in <= N_W'(1)) begin
                            result_q <= RES_W'(1);
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (last_bit_s) begin
                        // Truncate to RES_W; anything above is remembered as overflow.
                        acc_q      <= p_d[RES_W-1:0];
                        overflow_q <= overflow_q | (|p_d[P_W-1:RES_W]);
                        cnt_q      <= cnt_q - N_W'(1);
                        p_q        <= '0;
                        bit_q      <= '0;
                        if (cnt_q == N_W'(2)) begin
                            result_q <= p_d[RES_W-1:0];
                            state_q  <= S_DONE;
                        end
                    end else begin
                        p_q   <= p_d;
                        bit_q <= bit_q + B_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_factorial_seq.sv
// Directed bench for factorial_seq: a 64-bit instance and a 32-bit instance
// share clock and reset; one selected instance is driven at a time.
module tb_factorial_seq;
    logic clk = 1'b0;
    logic reset;
    logic sel32;
    logic start_s;
    logic [3:0] n_s;
    int   passed = 0;
    int   total  = 0;

    factorial_seq_if #(.N_W(4), .RES_W(64)) if64 ();
    factorial_seq_if #(.N_W(4), .RES_W(32)) if32 ();

    factorial_seq #(.N_W(4), .RES_W(64)) dut64 (.clk(clk), .reset(reset), .bus(if64.slave));
    factorial_seq #(.N_W(4), .RES_W(32)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));

    assign if64.start = start_s & ~sel32;
    assign if32.start = start_s & sel32;
    assign if64.n_in  = n_s;
    assign if32.n_in  = n_s;

    wire        done_m = sel32 ? if32.done     : if64.done;
    wire        busy_m = sel32 ? if32.busy     : if64.busy;
    wire        ovf_m  = sel32 ? if32.overflow : if64.overflow;
    wire [63:0] res_m  = sel32 ? {32'd0, if32.result} : if64.result;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one computation, follow it to done and check latency, busy, result and overflow.
    task automatic run(input string tag, input logic [3:0] n, input int exp_cyc,
                       input logic [63:0] exp_res, input logic exp_ovf);
        int   cyc;
        logic busy_ok;
        n_s = n;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        n_s = 4'hA;
        cyc = 1;
        busy_ok = 1'b1;
        while (!done_m && cyc < 200) begin
            if (!busy_m) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        if (!busy_m) busy_ok = 1'b0;
        chk({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, " result"}, res_m, exp_res);
        chk({tag, " overflow"}, 64'(ovf_m), 64'(exp_ovf));
        chk({tag, " busy_through_done"}, 64'(busy_ok), 64'd1);
        tick();
        chk({tag, " done_one_cycle"}, 64'(done_m), 64'd0);
        chk({tag, " busy_after"}, 64'(busy_m), 64'd0);
        chk({tag, " result_held"}, res_m, exp_res);
    endtask

    initial begin
        int   cyc;
        logic saw_done;
        reset = 1'b1;
        sel32 = 1'b0;
        start_s = 1'b0;
        n_s = 4'd0;
        tick();
        tick();
        chk("reset busy", 64'(if64.busy), 64'd0);
        chk("reset done", 64'(if64.done), 64'd0);
        chk("reset result", if64.result, 64'd0);
        chk("reset overflow", 64'(if64.overflow), 64'd0);
        reset = 1'b0;
        tick();

        run("n0", 4'd0, 1, 64'd1, 1'b0);
        run("n1", 4'd1, 1, 64'd1, 1'b0);
        run("n5", 4'd5, 17, 64'd120, 1'b0);
        run("n2", 4'd2, 5, 64'd2, 1'b0);
        run("n15", 4'd15, 57, 64'd1307674368000, 1'b0);

        sel32 = 1'b1;
        run("w32 n13", 4'd13, 49, 64'd1932053504, 1'b1);
        run("w32 n3", 4'd3, 9, 64'd6, 1'b0);
        sel32 = 1'b0;

        // n=4 with stray start pulses in MUL and in the DONE cycle.
        n_s = 4'd4;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        cyc = 1;
        while (!done_m && cyc < 200) begin
            if (cyc == 5) begin
                start_s = 1'b1;
                n_s = 4'd7;
            end else begin
                start_s = 1'b0;
            end
            tick();
            cyc++;
        end
        chk("n4 done_cycle", 64'(cyc), 64'd13);
        chk("n4 result", res_m, 64'd24);
        start_s = 1'b1;
        n_s = 4'd7;
        tick();
        start_s = 1'b0;
        chk("n4 start_in_done_ignored", 64'(busy_m), 64'd0);
        chk("n4 result_kept", res_m, 64'd24);
        run("n7", 4'd7, 25, 64'd5040, 1'b0);

        // Reset in the middle of n=9.
        n_s = 4'd9;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("n9 busy_mid", 64'(busy_m), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset busy", 64'(busy_m), 64'd0);
        chk("midreset result", res_m, 64'd0);
        chk("midreset done", 64'(done_m), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_m || busy_m) saw_done = 1'b1;
        end
        chk("midreset no_activity", 64'(saw_done), 64'd0);
        run("after_reset n3", 4'd3, 9, 64'd6, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
